encode_pack: RTL and testbench

Inverse of the instruction decode stage. Accepts decoded Thumb-16 fields (opcode, reg1..reg3, r_list, cond, offset), re-encodes each into a 16-bit halfword, and packs two halfwords little-endian into a 32-bit instruction-memory write word. Used by the program loader and as a round-trip checker against decode.

---
 rtl/thumb_pkg.sv | 51 +++++
 rtl/thumb_hw_encode.sv | 71 +++++++
 rtl/encode_pack.sv | 130 +++++++++++++
 tb/tb_encode_pack.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thumb_pkg.sv
// Shared opcode codes, packer state encoding and immediate-field geometry
// for the Thumb-16 re-encoder.
package thumb_pkg;

    // Decoded opcode codes as produced by the decode stage
    localparam logic [4:0] OP_MOVS   = 5'd0;
    localparam logic [4:0] OP_CMP    = 5'd1;
    localparam logic [4:0] OP_ADDS3  = 5'd2;
    localparam logic [4:0] OP_LDRLIT = 5'd3;
    localparam logic [4:0] OP_STR    = 5'd4;
    localparam logic [4:0] OP_LDR    = 5'd5;
    localparam logic [4:0] OP_ADDSP  = 5'd6;
    localparam logic [4:0] OP_SUBSP  = 5'd7;
    localparam logic [4:0] OP_PUSH   = 5'd8;
    localparam logic [4:0] OP_POP    = 5'd9;
    localparam logic [4:0] OP_BCOND  = 5'd10;
    localparam logic [4:0] OP_B      = 5'd11;
    localparam logic [4:0] OP_MOVHI  = 5'd12;

    // Halfword used to pad the high half of a word flushed early
    localparam logic [15:0] NOP_HW_DEFAULT = 16'hBF00;

    // Packer occupancy: nothing held, low half held, full word presented
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } pack_state_e;

    // Immediate geometry: width 0 means the opcode carries no immediate
    typedef struct packed {
        logic [4:0] width;
        logic       is_signed;
    } imm_info_t;

    function automatic imm_info_t imm_info(input logic [4:0] op);
        imm_info_t info;
        info = '{width: 5'd0, is_signed: 1'b0};
        case (op)
            OP_MOVS, OP_CMP, OP_LDRLIT, OP_ADDSP: info.width = 5'd8;
            OP_ADDS3:                             info.width = 5'd3;
            OP_STR, OP_LDR:                       info.width = 5'd5;
            OP_SUBSP:                             info.width = 5'd7;
            OP_BCOND: info = '{width: 5'd8,  is_signed: 1'b1};
            OP_B:     info = '{width: 5'd11, is_signed: 1'b1};
            default:  info = '{width: 5'd0,  is_signed: 1'b0};
        endcase
        return info;
    endfunction

endpackage

// File: rtl/thumb_hw_encode.sv
// Combinational re-encoder: decoded fields -> one Thumb-16 halfword, plus
// flags for an unknown opcode and for an immediate that had to be truncated.
module thumb_hw_encode
    import thumb_pkg::*;
(
    input  logic [4:0]  opcode,
    input  logic [3:0]  reg1,
    input  logic [3:0]  reg2,
    input  logic [3:0]  reg3,
    input  logic [7:0]  r_list,
    input  logic [3:0]  cond,
    input  logic [15:0] offset,
    output logic [15:0] hw,
    output logic        legal,
    output logic        in_range
);

    imm_info_t   info;
    logic [15:0] hi_mask;
    logic [15:0] hi_bits;

    // Rn only ever uses its low three bits
    logic unused_rn_msb;
    assign unused_rn_msb = reg2[3];

    // Range check: bits above the field must be zero (unsigned) or all copies
    // of the field's sign bit (signed), so the signed mask includes the sign bit
    always_comb begin
        info     = imm_info(opcode);
        hi_mask  = 16'hFFFF;
        hi_bits  = 16'h0000;
        in_range = 1'b1;
        if (info.width != 5'd0) begin
            if (info.is_signed) begin
                hi_mask  = 16'hFFFF << (info.width - 5'd1);
                hi_bits  = offset & hi_mask;
                in_range = (hi_bits == 16'h0000) || (hi_bits == hi_mask);
            end else begin
                hi_mask  = 16'hFFFF << info.width;
                hi_bits  = offset & hi_mask;
                in_range = (hi_bits == 16'h0000);
            end
        end
    end

    // Field placement per opcode; immediates are simply truncated to the field
    always_comb begin
        hw    = 16'h0000;
        legal = 1'b1;
        case (opcode)
            OP_MOVS:   hw = {5'b00100, reg1[2:0], offset[7:0]};
            OP_CMP:    hw = {5'b00101, reg2[2:0], offset[7:0]};
            OP_ADDS3:  hw = {7'b0001110, offset[2:0], reg2[2:0], reg1[2:0]};
            OP_LDRLIT: hw = {5'b01001, reg1[2:0], offset[7:0]};
            OP_STR:    hw = {5'b01100, offset[4:0], reg2[2:0], reg1[2:0]};
            OP_LDR:    hw = {5'b01101, offset[4:0], reg2[2:0], reg1[2:0]};
            OP_ADDSP:  hw = {5'b10101, reg1[2:0], offset[7:0]};
            OP_SUBSP:  hw = {9'b101100001, offset[6:0]};
            OP_PUSH:   hw = {7'b1011010, reg1[0], r_list};
            OP_POP:    hw = {7'b1011110, reg1[0], r_list};
            OP_BCOND:  hw = {4'b1101, cond, offset[7:0]};
            OP_B:      hw = {5'b11100, offset[10:0]};
            OP_MOVHI:  hw = {8'b01000110, reg1[3], reg3, reg1[2:0]};
            default: begin
                hw    = 16'h0000;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/encode_pack.sv
// Re-encodes decoded Thumb-16 fields and packs two halfwords little-endian
// into 32-bit instruction-memory write words with an incrementing address.
module encode_pack
    import thumb_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [15:0]       NOP_HW    = NOP_HW_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [3:0]        in_reg1,
    input  logic [3:0]        in_reg2,
    input  logic [3:0]        in_reg3,
    input  logic [7:0]        in_r_list,
    input  logic [3:0]        in_cond,
    input  logic [15:0]       in_offset,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    output logic              err_range
);

    pack_state_e       state_q, state_d;
    logic [15:0]       pend_lo_q, pend_lo_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_ill_q, err_ill_d;
    logic              err_rng_q, err_rng_d;

    logic [15:0] hw;
    logic        legal;
    logic        in_range;
    logic        accept;

    thumb_hw_encode u_enc (
        .opcode   (in_opcode),
        .reg1     (in_reg1),
        .reg2     (in_reg2),
        .reg3     (in_reg3),
        .r_list   (in_r_list),
        .cond     (in_cond),
        .offset   (in_offset),
        .hw       (hw),
        .legal    (legal),
        .in_range (in_range)
    );

    assign accept = in_valid && in_ready;

    // State register plus datapath flops; a low reset discards any pending half
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_EMPTY;
            pend_lo_q <= 16'h0000;
            data_q    <= 32'h0000_0000;
            addr_q    <= BASE_ADDR;
            err_ill_q <= 1'b0;
            err_rng_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_lo_q <= pend_lo_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            err_ill_q <= err_ill_d;
            err_rng_q <= err_rng_d;
        end
    end

    // Next state: illegal opcodes never add a halfword but can still flush
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept && legal) state_d = in_last ? ST_FULL : ST_HALF;
            ST_HALF:  if (accept && (legal || in_last)) state_d = ST_FULL;
            ST_FULL:  if (out_ready) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Datapath: the output word only changes when a word completes, so it
    // stays put while the next low half is being collected
    always_comb begin
        pend_lo_d = pend_lo_q;
        data_d    = data_q;
        addr_d    = addr_q;
        err_ill_d = err_ill_q;
        err_rng_d = err_rng_q;
        if (accept) begin
            if (!legal)         err_ill_d = 1'b1;
            else if (!in_range) err_rng_d = 1'b1;
        end
        case (state_q)
            ST_EMPTY: begin
                if (accept && legal) begin
                    pend_lo_d = hw;
                    if (in_last) data_d = {NOP_HW, hw};
                end
            end
            ST_HALF: begin
                if (accept) begin
                    if (legal)        data_d = {hw, pend_lo_q};
                    else if (in_last) data_d = {NOP_HW, pend_lo_q};
                end
            end
            ST_FULL: begin
                if (out_ready) addr_d = addr_q + ADDR_W'(4);
            end
            default: ;
        endcase
    end

    // Handshake outputs decoded from occupancy
    always_comb begin
        in_ready  = (state_q != ST_FULL);
        out_valid = (state_q == ST_FULL);
    end

    assign out_data    = data_q;
    assign out_addr    = addr_q;
    assign err_illegal = err_ill_q;
    assign err_range   = err_rng_q;

endmodule

// File: tb/tb_encode_pack.sv
// Self-checking bench for encode_pack: table of known encodings, hand-written
// corner sequences, then randomized streams against a behavioural model.
module tb_encode_pack;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_opcode = '0;
    logic [3:0]  in_reg1 = '0, in_reg2 = '0, in_reg3 = '0;
    logic [7:0]  in_r_list = '0;
    logic [3:0]  in_cond = '0;
    logic [15:0] in_offset = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [15:0] out_addr;
    logic        err_illegal;
    logic        err_range;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    encode_pack #(.ADDR_W(16), .BASE_ADDR(16'h0000), .NOP_HW(16'hBF00)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_reg1(in_reg1), .in_reg2(in_reg2), .in_reg3(in_reg3),
        .in_r_list(in_r_list), .in_cond(in_cond), .in_offset(in_offset), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr),
        .err_illegal(err_illegal), .err_range(err_range)
    );

    typedef struct {
        logic [4:0]  op;
        logic [3:0]  r1, r2, r3;
        logic [7:0]  rl;
        logic [3:0]  cond;
        logic [15:0] off;
        logic [15:0] hw;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [15:0] addr;
        bit          ill;
        bit          rng;
    } word_t;

    vec_t  tbl[14];
    word_t exp_q[$];

    // behavioural model state
    bit          m_have;
    logic [15:0] m_lo;
    int          m_addr;
    bit          m_ill, m_rng;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Encoding computed with plain arithmetic from opcode rules
    function automatic void ref_encode(input int op, input int r1, input int r2, input int r3,
                                       input int rl, input int cnd, input logic [15:0] off,
                                       output bit legal, output logic [15:0] hw, output bit ok);
        int o, so, v;
        o = int'(off);
        so = int'($signed(off));
        legal = 1; ok = 1; v = 0;
        case (op)
            0:  begin v = 'h2000 + (r1 % 8) * 256 + o % 256; ok = o < 256; end
            1:  begin v = 'h2800 + (r2 % 8) * 256 + o % 256; ok = o < 256; end
            2:  begin v = 'h1C00 + (o % 8) * 64 + (r2 % 8) * 8 + r1 % 8; ok = o < 8; end
            3:  begin v = 'h4800 + (r1 % 8) * 256 + o % 256; ok = o < 256; end
            4:  begin v = 'h6000 + (o % 32) * 64 + (r2 % 8) * 8 + r1 % 8; ok = o < 32; end
            5:  begin v = 'h6800 + (o % 32) * 64 + (r2 % 8) * 8 + r1 % 8; ok = o < 32; end
            6:  begin v = 'hA800 + (r1 % 8) * 256 + o % 256; ok = o < 256; end
            7:  begin v = 'hB080 + o % 128; ok = o < 128; end
            8:  v = 'hB400 + (r1 % 2) * 256 + rl;
            9:  v = 'hBC00 + (r1 % 2) * 256 + rl;
            10: begin v = 'hD000 + cnd * 256 + o % 256; ok = (so >= -128) && (so < 128); end
            11: begin v = 'hE000 + o % 2048; ok = (so >= -1024) && (so < 1024); end
            12: v = 'h4600 + (r1 / 8) * 128 + r3 * 8 + r1 % 8;
            default: begin legal = 0; v = 0; end
        endcase
        hw = 16'(v);
    endfunction

    function automatic void model_reset();
        m_have = 0; m_lo = 0; m_addr = 0; m_ill = 0; m_rng = 0;
        exp_q.delete();
    endfunction

    function automatic void model_push(input logic [31:0] d);
        word_t w;
        w.data = d; w.addr = 16'(m_addr); w.ill = m_ill; w.rng = m_rng;
        exp_q.push_back(w);
        m_addr = (m_addr + 4) % 65536;
    endfunction

    function automatic void model_accept(input vec_t v, input bit last);
        bit legal, ok;
        logic [15:0] hw;
        ref_encode(int'(v.op), int'(v.r1), int'(v.r2), int'(v.r3), int'(v.rl), int'(v.cond),
                   v.off, legal, hw, ok);
        if (!legal) begin
            m_ill = 1;
            if (m_have && last) begin
                model_push({16'hBF00, m_lo});
                m_have = 0;
            end
        end else begin
            if (!ok) m_rng = 1;
            if (m_have) begin
                model_push({hw, m_lo});
                m_have = 0;
            end else if (last) begin
                model_push({16'hBF00, hw});
            end else begin
                m_have = 1; m_lo = hw;
            end
        end
    endfunction

    function automatic vec_t mk(input logic [4:0] op, input logic [3:0] r1, input logic [3:0] r2,
                                input logic [3:0] r3, input logic [7:0] rl, input logic [3:0] cnd,
                                input logic [15:0] off, input logic [15:0] hw);
        vec_t v;
        v.op = op; v.r1 = r1; v.r2 = r2; v.r3 = r3; v.rl = rl; v.cond = cnd; v.off = off; v.hw = hw;
        return v;
    endfunction

    task automatic drive(input vec_t v, input bit last);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'h1);
        in_opcode = v.op; in_reg1 = v.r1; in_reg2 = v.r2; in_reg3 = v.r3;
        in_r_list = v.rl; in_cond = v.cond; in_offset = v.off; in_last = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    // Wait for a word, hold it for 'stall' cycles checking stability, then take it
    task automatic take_word(input string name, input logic [31:0] exp_data,
                             input logic [15:0] exp_addr, input int stall);
        int n;
        @(negedge clk);
        n = 0;
        while (!out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, 32'(out_valid), 32'h1);
        check({name, "_in_ready_low"}, 32'(in_ready), 32'h0);
        for (int s = 0; s < stall; s++) begin
            check({name, "_hold_data"}, out_data, exp_data);
            @(negedge clk);
        end
        check({name, "_data"}, out_data, exp_data);
        check({name, "_addr"}, 32'(out_addr), 32'(exp_addr));
        $display("word %s data=0x%08h addr=0x%04h", name, out_data, out_addr);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        check({name, "_in_ready"}, 32'(in_ready), 32'h1);
        check({name, "_out_valid"}, 32'(out_valid), 32'h0);
        check({name, "_out_data"}, out_data, 32'h0);
        check({name, "_out_addr"}, 32'(out_addr), 32'h0);
        check({name, "_err_ill"}, 32'(err_illegal), 32'h0);
        check({name, "_err_rng"}, 32'(err_range), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int stall;

        tbl[0]  = mk(5'd8,  4'd1,  4'd0, 4'd0, 8'h80, 4'd0,   16'h0000, 16'hB580);
        tbl[1]  = mk(5'd6,  4'd7,  4'd0, 4'd0, 8'h00, 4'd0,   16'h0002, 16'hAF02);
        tbl[2]  = mk(5'd3,  4'd2,  4'd0, 4'd0, 8'h00, 4'd0,   16'h0008, 16'h4A08);
        tbl[3]  = mk(5'd0,  4'd3,  4'd0, 4'd0, 8'h00, 4'd0,   16'h0000, 16'h2300);
        tbl[4]  = mk(5'd10, 4'd0,  4'd0, 4'd0, 8'h00, 4'hD,   16'hFFF6, 16'hDDF6);
        tbl[5]  = mk(5'd12, 4'd13, 4'd0, 4'd7, 8'h00, 4'd0,   16'h0000, 16'h46BD);
        tbl[6]  = mk(5'd1,  4'd0,  4'd5, 4'd0, 8'h00, 4'd0,   16'h002A, 16'h2D2A);
        tbl[7]  = mk(5'd2,  4'd1,  4'd2, 4'd0, 8'h00, 4'd0,   16'h0005, 16'h1D51);
        tbl[8]  = mk(5'd4,  4'd6,  4'd4, 4'd0, 8'h00, 4'd0,   16'h0003, 16'h60E6);
        tbl[9]  = mk(5'd5,  4'd7,  4'd0, 4'd0, 8'h00, 4'd0,   16'h001F, 16'h6FC7);
        tbl[10] = mk(5'd7,  4'd0,  4'd0, 4'd0, 8'h00, 4'd0,   16'h0010, 16'hB090);
        tbl[11] = mk(5'd11, 4'd0,  4'd0, 4'd0, 8'h00, 4'd0,   16'hFFFE, 16'hE7FE);
        tbl[12] = mk(5'd9,  4'd1,  4'd0, 4'd0, 8'h80, 4'd0,   16'h0000, 16'hBD80);
        tbl[13] = mk(5'd11, 4'd0,  4'd0, 4'd0, 8'h00, 4'd0,   16'h03FF, 16'hE3FF);

        // reset state
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check_idle("reset");

        // table: pairs pack into words at consecutive addresses
        for (int i = 0; i < 14; i += 2) begin
            drive(tbl[i], 1'b0);
            @(negedge clk);
            check($sformatf("tbl%0d_half_no_valid", i), 32'(out_valid), 32'h0);
            drive(tbl[i + 1], 1'b0);
            stall = (i == 2) ? 3 : (i / 2) % 3;
            take_word($sformatf("tbl%0d", i), {tbl[i + 1].hw, tbl[i].hw}, 16'(i * 2), stall);
        end
        @(negedge clk);
        check("tbl_err_ill", 32'(err_illegal), 32'h0);
        check("tbl_err_rng", 32'(err_range), 32'h0);

        // odd final instruction in EMPTY is padded with the NOP halfword
        drive(tbl[12], 1'b1);
        take_word("pop_last", 32'hBF00BD80, 16'h001C, 1);

        // illegal opcode in EMPTY: consumed, nothing produced
        drive(mk(5'd31, 4'd0, 4'd0, 4'd0, 8'h00, 4'd0, 16'h0000, 16'h0000), 1'b1);
        @(negedge clk);
        check("ill_flag", 32'(err_illegal), 32'h1);
        check("ill_no_word", 32'(out_valid), 32'h0);
        check("ill_in_ready", 32'(in_ready), 32'h1);

        // illegal in HALF without last stays HALF; with last flushes with pad
        drive(mk(5'd0, 4'd1, 4'd0, 4'd0, 8'h00, 4'd0, 16'h0001, 16'h2101), 1'b0);
        drive(mk(5'd20, 4'd0, 4'd0, 4'd0, 8'h00, 4'd0, 16'h0000, 16'h0000), 1'b0);
        @(negedge clk);
        check("ill_half_no_word", 32'(out_valid), 32'h0);
        drive(mk(5'd31, 4'd0, 4'd0, 4'd0, 8'h00, 4'd0, 16'h0000, 16'h0000), 1'b1);
        take_word("ill_flush", 32'hBF002101, 16'h0020, 0);
        check("rng_before", 32'(err_range), 32'h0);

        // out-of-range unsigned immediate is truncated and flagged
        drive(tbl[4], 1'b0);
        drive(mk(5'd0, 4'd3, 4'd0, 4'd0, 8'h00, 4'd0, 16'h0100, 16'h2300), 1'b0);
        take_word("range_movs", 32'h2300DDF6, 16'h0024, 1);
        check("rng_after", 32'(err_range), 32'h1);

        // reset mid-word discards the pending half
        drive(tbl[3], 1'b0);
        do_reset();
        check_idle("reset_half");
        drive(tbl[0], 1'b0);
        drive(tbl[1], 1'b0);
        take_word("after_reset", 32'hAF02B580, 16'h0000, 0);

        // signed boundary: -1024 fits eleven bits, +1024 does not
        drive(mk(5'd11, 4'd0, 4'd0, 4'd0, 8'h00, 4'd0, 16'hFC00, 16'hE400), 1'b0);
        @(negedge clk);
        check("b_min_rng", 32'(err_range), 32'h0);
        drive(mk(5'd11, 4'd0, 4'd0, 4'd0, 8'h00, 4'd0, 16'h0400, 16'hE400), 1'b0);
        take_word("b_bound", 32'hE400E400, 16'h0004, 0);
        check("b_over_rng", 32'(err_range), 32'h1);

        // randomized stream against the behavioural model
        do_reset();
        for (int n = 0; n < 80; n++) begin
            bit last;
            v.op = 5'($urandom_range(0, 15));
            v.r1 = 4'($urandom); v.r2 = 4'($urandom); v.r3 = 4'($urandom);
            v.rl = 8'($urandom); v.cond = 4'($urandom); v.hw = '0;
            case ($urandom_range(0, 3))
                0: v.off = 16'($urandom);
                1: v.off = 16'($urandom_range(0, 7));
                2: v.off = 16'($urandom_range(0, 127));
                default: v.off = 16'(16'hFFFF - 16'($urandom_range(0, 200)));
            endcase
            last = ($urandom_range(0, 5) == 0);
            if (n == 79) last = 1;
            model_accept(v, last);
            drive(v, last);
            while (exp_q.size() > 0) begin
                word_t w;
                w = exp_q.pop_front();
                take_word($sformatf("rnd%0d", n), w.data, w.addr, $urandom_range(0, 2));
                check("rnd_err_ill", 32'(err_illegal), 32'(w.ill));
                check("rnd_err_rng", 32'(err_range), 32'(w.rng));
            end
        end
        if (m_have) begin
            v = mk(5'd31, 4'd0, 4'd0, 4'd0, 8'h00, 4'd0, 16'h0000, 16'h0000);
            model_accept(v, 1'b1);
            drive(v, 1'b1);
            while (exp_q.size() > 0) begin
                word_t w;
                w = exp_q.pop_front();
                take_word("rnd_flush", w.data, w.addr, 0);
            end
        end
        @(negedge clk);
        check("rnd_final_ill", 32'(err_illegal), 32'(m_ill));
        check("rnd_final_rng", 32'(err_range), 32'(m_rng));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
